// File: rtl/async_fifo_fwft_pkg.sv
// async_fifo_fwft_pkg
// Shared constants and helpers for the FIFO read-side output stage.
//   MAX_RD_LATENCY  : largest supported memory read latency
//   LEVEL_W         : width of the buffered-word count / pointers
//   rd_latency_ok() : elaboration-time legality check for RD_LATENCY
//   ptr_inc()       : circular pointer increment with explicit wrap
package async_fifo_fwft_pkg;

    localparam int MAX_RD_LATENCY = 2;
    localparam int LEVEL_W        = 2;

    // Only latencies 1 and 2 are supported by the credit scheme.
    function automatic bit rd_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // Buffer depth need not be a power of two, so wrap by compare-and-clear.
    function automatic logic [LEVEL_W-1:0] ptr_inc(
        input logic [LEVEL_W-1:0] ptr,
        input logic [LEVEL_W-1:0] last_idx
    );
        if (ptr == last_idx) begin
            return 2'd0;
        end else begin
            return ptr + 2'd1;
        end
    endfunction

endpackage

// File: rtl/async_fifo_fwft.sv
// async_fifo_fwft
// Read-side output stage of the async FIFO: turns the rd_en/empty port
// (read data lagging rd_en by RD_LATENCY cycles) into a first-word-fall-
// through valid/ready stream, using a small credit-tracked skid buffer.
// Ports:
//   clk, rst      : read-domain clock, synchronous active-high reset
//   fifo_empty    : registered empty flag from the read controller
//   fifo_rd_en    : pop request to the read controller
//   fifo_rd_data  : memory read data, valid RD_LATENCY cycles after rd_en
//   m_valid/m_data/m_ready : output stream
//   m_level       : buffered word count (0 .. RD_LATENCY+1)
module async_fifo_fwft
    import async_fifo_fwft_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready,
    output logic [1:0]        m_level
);

    localparam int                 BDEPTH    = RD_LATENCY + 1;
    localparam logic [LEVEL_W-1:0] LAST_IDX  = LEVEL_W'(BDEPTH - 1);
    localparam logic [2:0]         BDEPTH_W3 = 3'(BDEPTH);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("async_fifo_fwft: RD_LATENCY must be 1 or 2");
    end

    // Array is sized for the largest depth; pointers only ever reach LAST_IDX.
    logic [DWIDTH-1:0]     buf_r [4];
    logic [LEVEL_W-1:0]    head_r;
    logic [LEVEL_W-1:0]    tail_r;
    logic [LEVEL_W-1:0]    count_r;
    logic                  valid_r;
    logic [RD_LATENCY-1:0] inflight_r;

    logic                  pop_s;
    logic                  capture_s;
    logic [LEVEL_W-1:0]    inflight_cnt_s;
    logic [LEVEL_W-1:0]    count_next_s;
    logic [RD_LATENCY-1:0] inflight_next_s;
    logic [2:0]            credit_used_s;
    logic [2:0]            credit_limit_s;

    assign pop_s     = valid_r & m_ready;
    assign capture_s = inflight_r[RD_LATENCY-1];

    assign m_valid = valid_r;
    assign m_data  = buf_r[head_r];
    assign m_level = count_r;

    // Count of reads issued whose data has not yet been captured.
    always_comb begin
        inflight_cnt_s = 2'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt_s = inflight_cnt_s + {1'b0, inflight_r[i]};
        end
    end

    // Issue a read only while buffered plus in-flight words leave room;
    // a pop this cycle frees one slot early so streaming has no bubbles.
    always_comb begin
        credit_used_s  = {1'b0, count_r} + {1'b0, inflight_cnt_s};
        credit_limit_s = BDEPTH_W3 + {2'b00, pop_s};
        fifo_rd_en     = ~rst & ~fifo_empty & (credit_used_s < credit_limit_s);
    end

    // In-flight tracker advances one stage per cycle; new read enters at bit 0.
    always_comb begin
        inflight_next_s    = inflight_r << 1;
        inflight_next_s[0] = fifo_rd_en;
    end

    // Capture and pop together keep the count unchanged.
    always_comb begin
        count_next_s = count_r;
        if (capture_s && !pop_s) begin
            count_next_s = count_r + 2'd1;
        end else if (!capture_s && pop_s) begin
            count_next_s = count_r - 2'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Skid buffer storage, pointers, count and in-flight state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r     <= 2'd0;
            tail_r     <= 2'd0;
            count_r    <= 2'd0;
            valid_r    <= 1'b0;
            inflight_r <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            inflight_r <= inflight_next_s;
            count_r    <= count_next_s;
            valid_r    <= (count_next_s != 2'd0);
            if (capture_s) begin
                buf_r[tail_r] <= fifo_rd_data;
                tail_r        <= ptr_inc(tail_r, LAST_IDX);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r, LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_fwft.sv
// tb_async_fifo_fwft
// Two instances (RD_LATENCY 1 and 2) are driven side by side. Each has a
// behavioural read-controller model (word array + read latency pipe) and a
// reference model: expected beats follow FIFO write order, expected level is
// reads-landed minus beats-taken.
module tb_async_fifo_fwft;

    localparam int DW        = 32;
    localparam int SRC_DEPTH = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    fifo_empty;
    logic [1:0]    fifo_rd_en;
    logic [1:0]    m_valid;
    logic [1:0]    m_ready;
    logic [DW-1:0] fifo_rd_data [2];
    logic [DW-1:0] m_data [2];
    logic [1:0]    m_level [2];

    async_fifo_fwft #(.DWIDTH(DW), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
        .fifo_rd_data(fifo_rd_data[0]), .m_valid(m_valid[0]), .m_data(m_data[0]),
        .m_ready(m_ready[0]), .m_level(m_level[0])
    );

    async_fifo_fwft #(.DWIDTH(DW), .RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
        .fifo_rd_data(fifo_rd_data[1]), .m_valid(m_valid[1]), .m_data(m_data[1]),
        .m_ready(m_ready[1]), .m_level(m_level[1])
    );

    logic [DW-1:0] src_mem [2][SRC_DEPTH];
    int            src_w [2];
    int            src_r [2];
    int            beat_cnt [2];
    int            exp_lvl [2];
    bit            rd_hist [2][3];
    logic [DW-1:0] dpipe [2][2];
    logic [DW-1:0] popped [2];
    bit            prev_hold [2];
    logic [DW-1:0] prev_data [2];
    int            first_rd [2];
    int            first_val [2];
    int            first_beat [2];
    int            last_beat [2];
    int            nbeat [2];
    int            cyc;
    int            ready_pct;
    int            push_pct;
    int            n_vec;
    int            n_err;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic string ltag(input string name, input int l);
        return $sformatf("%s_lat%0d", name, l + 1);
    endfunction

    task automatic push_word(input int l, input logic [DW-1:0] v);
        if (src_w[l] < SRC_DEPTH) begin
            src_mem[l][src_w[l]] = v;
            src_w[l]++;
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < 2; l++) begin
            src_w[l]     = 0;
            src_r[l]     = 0;
            beat_cnt[l]  = 0;
            exp_lvl[l]   = 0;
            prev_hold[l] = 1'b0;
            for (int k = 0; k < 3; k++) rd_hist[l][k] = 1'b0;
        end
    endtask

    task automatic arm_marks();
        for (int l = 0; l < 2; l++) begin
            first_rd[l]   = -1;
            first_val[l]  = -1;
            first_beat[l] = -1;
            last_beat[l]  = -1;
            nbeat[l]      = 0;
        end
    endtask

    // One read-clock cycle: drive at negedge, sample 1 ns later, update models.
    task automatic step();
        int lat;
        bit beat;
        bit cap;
        for (int l = 0; l < 2; l++) begin
            lat             = l + 1;
            fifo_empty[l]   = (src_w[l] == src_r[l]);
            dpipe[l][1]     = dpipe[l][0];
            dpipe[l][0]     = popped[l];
            fifo_rd_data[l] = dpipe[l][lat-1];
            m_ready[l]      = ($urandom_range(99) < ready_pct);
        end
        #1;
        for (int l = 0; l < 2; l++) begin
            lat = l + 1;
            check_eq(ltag("rd_en_while_empty", l), DW'(fifo_rd_en[l] & fifo_empty[l]), 32'd0);
            check_eq(ltag("level", l), DW'(m_level[l]), DW'(exp_lvl[l]));
            check_eq(ltag("valid", l), DW'(m_valid[l]), DW'(exp_lvl[l] != 0));
            check_eq(ltag("level_bound", l), DW'(exp_lvl[l] <= lat + 1), 32'd1);
            if (prev_hold[l]) begin
                check_eq(ltag("hold_valid", l), DW'(m_valid[l]), 32'd1);
                check_eq(ltag("hold_data", l), m_data[l], prev_data[l]);
            end
            beat = m_valid[l] & m_ready[l];
            if (beat) begin
                check_eq(ltag("beat_data", l), m_data[l], src_mem[l][beat_cnt[l]]);
                beat_cnt[l]++;
                if (first_beat[l] < 0) first_beat[l] = cyc;
                last_beat[l] = cyc;
                nbeat[l]++;
            end
            if (m_valid[l] && first_val[l] < 0) first_val[l] = cyc;
            if (fifo_rd_en[l]) begin
                popped[l] = src_mem[l][src_r[l]];
                src_r[l]++;
                if (first_rd[l] < 0) first_rd[l] = cyc;
            end else begin
                popped[l] = $urandom;
            end
            rd_hist[l][2] = rd_hist[l][1];
            rd_hist[l][1] = rd_hist[l][0];
            rd_hist[l][0] = fifo_rd_en[l];
            cap = rd_hist[l][lat];
            exp_lvl[l] = exp_lvl[l] + int'(cap) - int'(beat);
            prev_hold[l] = m_valid[l] & ~m_ready[l];
            prev_data[l] = m_data[l];
            if ($urandom_range(99) < push_pct) push_word(l, $urandom);
        end
        cyc++;
        @(negedge clk);
    endtask

    // Hold rst for ncyc cycles while any in-flight data keeps arriving.
    task automatic reset_cycles(input int ncyc);
        rst = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            for (int l = 0; l < 2; l++) begin
                dpipe[l][1]     = dpipe[l][0];
                dpipe[l][0]     = popped[l];
                fifo_rd_data[l] = dpipe[l][l];
                popped[l]       = $urandom;
                m_ready[l]      = 1'b0;
                fifo_empty[l]   = (src_w[l] == src_r[l]);
            end
            #1;
            for (int l = 0; l < 2; l++) begin
                check_eq(ltag("rd_en_in_reset", l), DW'(fifo_rd_en[l]), 32'd0);
            end
            cyc++;
            @(negedge clk);
        end
        rst = 1'b0;
        clear_model();
        #1;
        for (int l = 0; l < 2; l++) begin
            check_eq(ltag("rst_valid", l), DW'(m_valid[l]), 32'd0);
            check_eq(ltag("rst_level", l), DW'(m_level[l]), 32'd0);
            check_eq(ltag("rst_data", l), m_data[l], 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        ready_pct  = 0;
        push_pct   = 0;
        rst        = 1'b1;
        fifo_empty = 2'b11;
        m_ready    = 2'b00;
        for (int l = 0; l < 2; l++) begin
            fifo_rd_data[l] = '0;
            popped[l]       = '0;
            dpipe[l][0]     = '0;
            dpipe[l][1]     = '0;
        end
        clear_model();
        arm_marks();
        @(negedge clk);
        reset_cycles(3);

        // Preloaded 0x10..0x17, consumer always ready.
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 8; i++) push_word(l, 32'h10 + DW'(i));
        ready_pct = 100;
        arm_marks();
        for (int k = 0; k < 16; k++) step();
        for (int l = 0; l < 2; l++) begin
            check_eq(ltag("first_latency", l), DW'(first_val[l] - first_rd[l]), DW'(l + 2));
            check_eq(ltag("burst_beats", l), DW'(nbeat[l]), 32'd8);
            check_eq(ltag("burst_span", l), DW'(last_beat[l] - first_beat[l]), 32'd7);
        end

        // Backpressure: stream, stall 5 cycles, resume and drain.
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 24; i++) push_word(l, 32'h100 + DW'(i));
        ready_pct = 100;
        for (int k = 0; k < 4; k++) step();
        ready_pct = 0;
        for (int k = 0; k < 5; k++) step();
        for (int l = 0; l < 2; l++) begin
            check_eq(ltag("stall_level_full", l), DW'(m_level[l]), DW'(l + 2));
            check_eq(ltag("stall_rd_en_low", l), DW'(fifo_rd_en[l]), 32'd0);
        end
        ready_pct = 100;
        for (int k = 0; k < 30; k++) step();
        for (int l = 0; l < 2; l++)
            check_eq(ltag("stall_drain_all", l), DW'(beat_cnt[l]), DW'(src_w[l]));

        // FIFO runs dry after three words.
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 3; i++) push_word(l, 32'hA0 + DW'(i));
        arm_marks();
        for (int k = 0; k < 10; k++) step();
        for (int l = 0; l < 2; l++) begin
            check_eq(ltag("dry_beats", l), DW'(nbeat[l]), 32'd3);
            check_eq(ltag("dry_valid_low", l), DW'(m_valid[l]), 32'd0);
        end

        // Reset with words buffered and in flight; nothing may surface after.
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 10; i++) push_word(l, 32'hC0 + DW'(i));
        ready_pct = 0;
        for (int k = 0; k < 2; k++) step();
        reset_cycles(1);
        ready_pct = 100;
        for (int k = 0; k < 5; k++) step();

        // Random consumer and random refill against the scoreboard.
        ready_pct = 50;
        push_pct  = 45;
        for (int k = 0; k < 60000; k++) begin
            if (beat_cnt[0] >= 10000 && beat_cnt[1] >= 10000) break;
            step();
        end
        push_pct  = 0;
        ready_pct = 100;
        for (int k = 0; k < 20; k++) step();
        for (int l = 0; l < 2; l++) begin
            check_eq(ltag("random_done", l), DW'(beat_cnt[l] >= 10000), 32'd1);
            check_eq(ltag("random_drain_all", l), DW'(beat_cnt[l]), DW'(src_w[l]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
